serializer_tx: RTL
==================

SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 The module SHALL have parameter TRAIN_PATTERN, default 10'b0110011010, the training word sent MSB first.
REQ-002 The module SHALL have parameter TRAIN_WORDS, default 4, the number of consecutive training words per training burst (range 1..15).
REQ-003 The module SHALL have parameter FILL_WORD, default 10'h000, the word sent when no payload is available.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The module SHALL have port enable, input, 1; high = advance one bit per cycle, low = freeze.
REQ-007 The module SHALL have port start, input, 1, a request to begin or restart a training burst.
REQ-008 The module SHALL have port data_in, input, 10, the payload word.
REQ-009 The module SHALL have port data_valid, input, 1, meaning data_in holds a word to send.
REQ-010 The module SHALL have port data_ready, output, 1; high = a word is accepted this cycle if data_valid is high.
REQ-011 The module SHALL have port serial_out, output, 1, the registered serial bit stream, 1 bit per clock.
REQ-012 The module SHALL have port train_done, output, 1, high after the first training burst completes.
REQ-013 The module SHALL have port tx_busy, output, 1, high whenever the state is not IDLE.
REQ-014 The module SHALL have port underrun, output, 1, a 1-cycle pulse when FILL_WORD is loaded in DATA.

Function
REQ-015 The block SHALL implement FSM states IDLE, TRAIN and DATA, with a 4-bit bit counter (0..9), a 4-bit training-word counter and a 10-bit shift register whose MSB drives serial_out.
REQ-016 Bit order SHALL be MSB first: word bit 9 is on serial_out in the first cycle after load, bit 0 in the tenth.
REQ-017 In IDLE, serial_out SHALL be 0, the counters SHALL be held at 0, and data_ready SHALL be 0.
REQ-018 On start=1 with enable=1 in IDLE at cycle N, the block SHALL load TRAIN_PATTERN and enter TRAIN, so that serial_out = TRAIN_PATTERN[9] at cycle N+1.
REQ-019 TRAIN SHALL emit TRAIN_WORDS back-to-back copies of TRAIN_PATTERN, reloading at each bit_cnt==9 boundary with no gap cycles.
REQ-020 A word boundary SHALL be the cycle where bit_cnt==9; the next word's MSB appears on serial_out the following cycle.
REQ-021 data_ready SHALL be 1 only when enable=1 and bit_cnt==9, and only in DATA or during the last bit of the last training word.
REQ-022 At a boundary with data_ready=1: if data_valid=1, data_in SHALL be loaded; otherwise FILL_WORD SHALL be loaded and underrun SHALL pulse for that cycle.
REQ-023 After the last training bit (cycle N+10*TRAIN_WORDS), the state SHALL be DATA and train_done SHALL be set, then held until reset.
REQ-024 In DATA, start SHALL be latched as a pending retrain; at the next boundary TRAIN_PATTERN SHALL be loaded instead of payload, data_ready SHALL be 0 at that boundary, and the state SHALL return to TRAIN.
REQ-025 In TRAIN, start SHALL be ignored.
REQ-026 With enable=0, all registers SHALL hold, serial_out SHALL hold its value, and data_ready and underrun SHALL be 0; the stream SHALL resume from the same bit once enable returns.
REQ-027 data_valid without data_ready SHALL NOT consume a word; upstream holds data_in and data_valid until the handshake completes.

Reset
REQ-028 On rst_n=0, the block SHALL immediately force state=IDLE, counters=0, shift register=0, serial_out=0, data_ready=0, train_done=0, tx_busy=0, underrun=0, and pending retrain=0, including mid-word.
REQ-029 After reset release, the block SHALL remain in IDLE until start.

Verification
REQ-030 The bench SHALL check: reset, then start at cycle 5 -> serial_out cycles 6..45 = 0110011010 repeated 4 times, train_done=1 at cycle 46.
REQ-031 The bench SHALL check: data_valid held with data_in=10'h3A5 through the training end -> data_ready=1 at cycle 45 only, serial_out cycles 46..55 = 1110100101.
REQ-032 The bench SHALL check: data_valid=0 at a DATA boundary -> 10 zero bits, underrun pulses exactly once, data_ready stays 1 for only that cycle.
REQ-033 The bench SHALL check: enable low for 7 cycles mid-word -> output stalls, then the remaining bits continue in order with total bit count unchanged.
REQ-034 The bench SHALL check: start pulse mid-word in DATA -> the current word completes, then 4 training words, then data_ready re-asserts at their last bit; train_done stays 1.
REQ-035 The bench SHALL check: rst_n low at bit 3 of a payload word -> all outputs 0 that cycle, IDLE held until the next start, and a loopback into the deserializer re-aligns and recovers words bit-exact.

Source files
------------

// File: rtl/serializer_tx.sv
// rtl/serializer_tx.sv - 10-bit MSB-first serializer with training bursts and payload handshake
module serializer_tx #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'b0110011010,
  parameter int unsigned TRAIN_WORDS   = 4,
  parameter logic [9:0]  FILL_WORD     = 10'h000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic [9:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out,
  output logic       train_done,
  output logic       tx_busy,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, TRAIN, DATA} state_e;

  localparam logic [3:0] LAST_WORD = 4'(TRAIN_WORDS - 1);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] word_cnt_q, word_cnt_d;
  logic [9:0] shift_q, shift_d;
  logic       done_q, done_d;
  logic       pend_q, pend_d;
  logic       at_bnd;

  assign at_bnd     = (bit_cnt_q == 4'd9);
  assign serial_out = shift_q[9];
  assign train_done = done_q;
  assign tx_busy    = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    done_d     = done_q;
    pend_d     = pend_q;
    data_ready = 1'b0;
    underrun   = 1'b0;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            shift_d    = TRAIN_PATTERN;
            bit_cnt_d  = 4'd0;
            word_cnt_d = 4'd0;
            state_d    = TRAIN;
          end
        end
        TRAIN: begin
          if (at_bnd) begin
            bit_cnt_d = 4'd0;
            if (word_cnt_q == LAST_WORD) begin
              data_ready = 1'b1;
              underrun   = ~data_valid;
              shift_d    = data_valid ? data_in : FILL_WORD;
              word_cnt_d = 4'd0;
              done_d     = 1'b1;
              state_d    = DATA;
            end else begin
              word_cnt_d = word_cnt_q + 4'd1;
              shift_d    = TRAIN_PATTERN;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[8:0], 1'b0};
          end
        end
        DATA: begin
          if (at_bnd) begin
            bit_cnt_d = 4'd0;
            if (pend_q) begin
              // A retrain requested mid-word takes this boundary instead of payload.
              shift_d    = TRAIN_PATTERN;
              word_cnt_d = 4'd0;
              pend_d     = 1'b0;
              state_d    = TRAIN;
            end else begin
              data_ready = 1'b1;
              underrun   = ~data_valid;
              shift_d    = data_valid ? data_in : FILL_WORD;
              if (start) pend_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = {shift_q[8:0], 1'b0};
            if (start) pend_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      word_cnt_q <= 4'd0;
      shift_q    <= 10'd0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
    end
  end

endmodule
